// File: rtl/xdom_master_pkg.sv
// Shared frame constants, FSM encoding and request record for the xdom UART initiator.
// Frame bytes are derived from the captured request by index so the sequencer stays generic.
package xdom_master_pkg;

   localparam logic [7:0] XM_CMD_WR = 8'h57;
   localparam logic [7:0] XM_CMD_RD = 8'h52;
   localparam logic [2:0] XM_WR_LEN = 3'd5;
   localparam logic [2:0] XM_RD_LEN = 3'd3;

   typedef enum logic [2:0] {
      IDLE,
      TX_BYTE,
      RX_WAIT,
      RX_BYTE,
      DONE
   } xm_state_e;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [15:0] wdata;
   } xm_req_t;

   function automatic logic [7:0] xm_frame_byte(input xm_req_t req, input logic [2:0] idx);
      case (idx)
         3'd0:    return req.wr ? XM_CMD_WR : XM_CMD_RD;
         3'd1:    return {4'h0, req.addr[11:8]};
         3'd2:    return req.addr[7:0];
         3'd3:    return req.wdata[15:8];
         default: return req.wdata[7:0];
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Purpose: serialises one 8N1 byte, LSB first, idle-high line.
// Latency: start bit on the cycle after load; 10*CLKS_PER_BIT cycles per byte.
// Backpressure: load_rdy high when idle or in the last stop-bit cycle, so bytes chain with no gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_vld,
   input  logic [7:0] load_dat,
   output logic       load_rdy,
   output logic       txd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LIM = CW'(CLKS_PER_BIT - 1);

   logic          busy;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    sh;
   logic          last;

   assign last     = busy && (bit_cnt == 4'd9) && (clk_cnt == BIT_LIM);
   assign load_rdy = !busy || last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         clk_cnt <= '0;
         bit_cnt <= '0;
         sh      <= '1;
         txd     <= 1'b1;
      end else if (load_vld && load_rdy) begin
         busy    <= 1'b1;
         clk_cnt <= '0;
         bit_cnt <= '0;
         sh      <= {1'b1, load_dat};
         txd     <= 1'b0;
      end else if (busy) begin
         if (clk_cnt == BIT_LIM) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               busy <= 1'b0;
               txd  <= 1'b1;
            end else begin
               // sh carries data then the stop bit; refill with ones
               txd     <= sh[0];
               sh      <= {1'b1, sh[8:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/xdom_uart_master.sv
// Purpose: xdom debug-UART initiator; XDOM_MASTER_STOPCHK_EN makes a low response stop bit an error.
// Latency: write 50*CLKS_PER_BIT+1 cycles from accept; read ends at 2nd response byte mid-stop or on timeout.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is dropped, not queued.
module xdom_uart_master
   import xdom_master_pkg::*;
#(
   parameter int CLKS_PER_BIT     = 868,
   parameter int RSP_TIMEOUT_CLKS = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [11:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        uart_txd,
   input  logic        uart_rxd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(RSP_TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] BIT_LIM  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LIM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LIM   = TW'(RSP_TIMEOUT_CLKS - 1);

   xm_state_e     state, state_nxt;
   xm_req_t       req;
   logic [2:0]    tx_idx, frame_len;
   logic          tx_load_vld, tx_rdy;
   logic [7:0]    tx_load_dat;
   logic          rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, stop_bad;
   logic [CW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_sh, rx_hi;
   logic          rx_idx;
   logic [TW-1:0] to_cnt;
   logic          done_err;
   logic [15:0]   done_dat;

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_vld (tx_load_vld),
      .load_dat (tx_load_dat),
      .load_rdy (tx_rdy),
      .txd      (uart_txd)
   );

   assign frame_len = req.wr ? XM_WR_LEN : XM_RD_LEN;
   assign rx_fall   = rx_prev && !rx_s2;
   assign rx_tick   = (rx_cnt == ((rx_bit == 4'd0) ? HALF_LIM : BIT_LIM));
   assign cmd_ready = (state == IDLE);
   assign busy      = !cmd_ready;
   assign rsp_valid = (state == DONE);

`ifdef XDOM_MASTER_STOPCHK_EN
   assign stop_bad = !rx_s2;
`else
   assign stop_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      tx_load_vld = 1'b0;
      tx_load_dat = xm_frame_byte(req, tx_idx);
      done_err    = 1'b0;
      done_dat    = 16'h0;
      case (state)
         IDLE: begin
            tx_load_vld = cmd_valid;
            tx_load_dat = cmd_wr ? XM_CMD_WR : XM_CMD_RD;
            if (cmd_valid) state_nxt = TX_BYTE;
         end
         TX_BYTE: begin
            tx_load_vld = (tx_idx != frame_len);
            if (tx_rdy && (tx_idx == frame_len)) state_nxt = req.wr ? DONE : RX_WAIT;
         end
         RX_WAIT: begin
            if (rx_fall) begin
               state_nxt = RX_BYTE;
            end else if (to_cnt == TO_LIM) begin
               state_nxt = DONE;
               done_err  = 1'b1;
            end
         end
         RX_BYTE: begin
            if (rx_tick) begin
               if ((rx_bit == 4'd0) && rx_s2) begin
                  state_nxt = RX_WAIT;
               end else if (rx_bit == 4'd9) begin
                  if (stop_bad) begin
                     state_nxt = DONE;
                     done_err  = 1'b1;
                  end else if (rx_idx) begin
                     state_nxt = DONE;
                     done_dat  = {rx_hi, rx_sh};
                  end else begin
                     state_nxt = RX_WAIT;
                  end
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req       <= '0;
         tx_idx    <= '0;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_hi     <= '0;
         rx_idx    <= 1'b0;
         to_cnt    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rx_s1   <= uart_rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  req    <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
                  tx_idx <= 3'd1;
               end
            end
            TX_BYTE: begin
               if (tx_load_vld && tx_rdy) tx_idx <= tx_idx + 3'd1;
               to_cnt <= '0;
               rx_idx <= 1'b0;
            end
            RX_WAIT: begin
               to_cnt <= rx_fall ? '0 : to_cnt + 1'b1;
               rx_cnt <= '0;
               rx_bit <= '0;
            end
            RX_BYTE: begin
               if (rx_tick) begin
                  rx_cnt <= '0;
                  rx_bit <= rx_bit + 4'd1;
                  if ((rx_bit != 4'd0) && (rx_bit != 4'd9)) rx_sh <= {rx_s2, rx_sh[7:1]};
                  // first byte parked; inter-byte gap timed from its stop bit
                  if (rx_bit == 4'd9) begin
                     to_cnt <= '0;
                     rx_idx <= 1'b1;
                     rx_hi  <= rx_sh;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: ;
         endcase
         if ((state_nxt == DONE) && (state != DONE)) begin
            rsp_err   <= done_err;
            rsp_rdata <= done_dat;
         end
      end
   end

endmodule

// File: tb/tb_xdom_uart_master.sv
// Bench for xdom_uart_master: table vectors, hand-written corner sequences and randomized
// transactions against a behavioural responder on the serial line.
module tb_xdom_uart_master;

   localparam int CPB = 8;
   localparam int TO  = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [11:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid, rsp_err, busy, uart_txd, uart_rxd;
   logic [15:0] rsp_rdata;

   xdom_uart_master #(.CLKS_PER_BIT(CPB), .RSP_TIMEOUT_CLKS(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .uart_txd  (uart_txd),
      .uart_rxd  (uart_rxd)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] tx_q[$];
   logic [7:0] mon_b;
   logic       txd_prev = 1'b1;

   typedef struct {
      string       name;
      bit          wr;
      logic [11:0] addr;
      logic [15:0] wdata;
      int          mode;      // 0 no reply, 1 reply, 2 second byte bad stop, 3 glitch then reply
      logic [7:0]  r0, r1;
      bit          exp_err;
      logic [15:0] exp_rdata;
      logic [39:0] exp_frame;
      int          exp_lat;   // 0 when the reply timing makes latency open
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference frame: command byte then address and data split into bytes, MSB byte first.
   function automatic logic [39:0] model_frame(input bit wr, input logic [11:0] a, input logic [15:0] d);
      logic [39:0] f;
      f = '0;
      f[39:32] = wr ? 8'h57 : 8'h52;
      f[31:24] = 8'(a / 256);
      f[23:16] = 8'(a % 256);
      if (wr) begin
         f[15:8] = 8'(d / 256);
         f[7:0]  = 8'(d % 256);
      end
      return f;
   endfunction

   // Responder receive side: decode every 8N1 byte seen on uart_txd.
   initial begin : txmon
      forever begin
         @(negedge clk);
         if (rst_n && txd_prev && !uart_txd) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(mon_b);
         end
         txd_prev = uart_txd;
      end
   end

   task automatic send_byte(input logic [7:0] v, input bit stop);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = v[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (CPB) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic run_txn(input string nm, input bit wr, input logic [11:0] a, input logic [15:0] d,
                          input int mode, input logic [7:0] r0, input logic [7:0] r1,
                          input bit exp_err, input logic [15:0] exp_rdata,
                          input logic [39:0] exp_frame, input int exp_lat);
      int   len, k, wb, rb;
      logic got, got_err;
      logic [15:0] got_rdata;
      len = wr ? 5 : 3;
      wb  = 0;
      while (!cmd_ready && wb < 5000) begin @(negedge clk); wb++; end
      tx_q.delete();
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_wr = ~wr; cmd_addr = 12'($urandom); cmd_wdata = 16'($urandom);
      k = 1; rb = 0; got = 1'b0; got_err = 1'b0; got_rdata = '0;
      fork
         begin
            if (mode != 0) begin
               while (tx_q.size() < len && rb < 1000) begin @(negedge clk); rb++; end
               repeat (10 + $urandom_range(0, 20)) @(negedge clk);
               if (mode == 3) begin
                  uart_rxd = 1'b0;
                  repeat (2) @(negedge clk);
                  uart_rxd = 1'b1;
                  repeat (20) @(negedge clk);
               end
               send_byte(r0, 1'b1);
               repeat ($urandom_range(0, 40)) @(negedge clk);
               send_byte(r1, mode != 2);
            end
         end
         begin
            while (!rsp_valid && k < 4000) begin @(negedge clk); k++; end
            got = rsp_valid; got_err = rsp_err; got_rdata = rsp_rdata;
            @(negedge clk);
            chk({nm, "_pulse"}, 32'(rsp_valid), 32'd0);
            chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
         end
      join
      chk({nm, "_rsp_valid"}, 32'(got), 32'd1);
      if (exp_lat != 0) chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
      chk({nm, "_err"}, 32'(got_err), 32'(exp_err));
      chk({nm, "_rdata"}, 32'(got_rdata), 32'(exp_rdata));
      chk({nm, "_rdata_hold"}, 32'(rsp_rdata), 32'(exp_rdata));
      chk({nm, "_frame_len"}, 32'(tx_q.size()), 32'(len));
      for (int i = 0; i < len && i < tx_q.size(); i++)
         chk($sformatf("%s_byte%0d", nm, i), 32'(tx_q[i]), 32'(exp_frame[39-8*i -: 8]));
   endtask

   int seen, acc, wb;

   initial begin : main
      vecs[0] = '{"wr_8fe", 1'b1, 12'h8fe, 16'h1234, 0, 8'h00, 8'h00, 1'b0, 16'h0000, 40'h5708FE1234, 401};
      vecs[1] = '{"rd_fff", 1'b0, 12'hfff, 16'h0000, 1, 8'h00, 8'h01, 1'b0, 16'h0001, 40'h520FFF0000, 0};
      vecs[2] = '{"rd_timeout", 1'b0, 12'h123, 16'h0000, 0, 8'h00, 8'h00, 1'b1, 16'h0000, 40'h5201230000, 1241};
`ifdef XDOM_MASTER_STOPCHK_EN
      vecs[3] = '{"rd_badstop", 1'b0, 12'h456, 16'h0000, 2, 8'hAB, 8'hCD, 1'b1, 16'h0000, 40'h5204560000, 0};
`else
      vecs[3] = '{"rd_badstop", 1'b0, 12'h456, 16'h0000, 2, 8'hAB, 8'hCD, 1'b0, 16'hABCD, 40'h5204560000, 0};
`endif

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_txd", 32'(uart_txd), 32'd1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 4; v++)
         run_txn(vecs[v].name, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].mode,
                 vecs[v].r0, vecs[v].r1, vecs[v].exp_err, vecs[v].exp_rdata,
                 vecs[v].exp_frame, vecs[v].exp_lat);

      // start-bit glitch before the real response
      run_txn("rd_glitch", 1'b0, 12'h8ff, 16'h0, 3, 8'h5A, 8'hC3, 1'b0, 16'h5AC3,
              model_frame(1'b0, 12'h8ff, 16'h0), 0);

      // reset in the middle of the second write byte
      tx_q.delete();
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h8fe; cmd_wdata = 16'h1234;
      @(negedge clk);
      cmd_valid = 1'b0;
      wb = 0;
      while (tx_q.size() < 1 && wb < 200) begin @(negedge clk); wb++; end
      wb = 0;
      while (uart_txd && wb < 50) begin @(negedge clk); wb++; end
      chk("rst_mid_pre_txd", 32'(uart_txd), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_txd", 32'(uart_txd), 32'd1);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (500) begin @(negedge clk); if (rsp_valid) seen++; end
      chk("rst_mid_no_rsp", 32'(seen), 32'd0);
      run_txn("post_rst_wr", 1'b1, 12'h0a5, 16'hbeef, 0, 8'h0, 8'h0, 1'b0, 16'h0,
              model_frame(1'b1, 12'h0a5, 16'hbeef), 401);

      // cmd_valid held high: one frame per acceptance
      tx_q.delete();
      cmd_wr = 1'b1; cmd_addr = 12'h8ff; cmd_wdata = 16'h00ff; cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 450; i++) begin
         if (cmd_valid && cmd_ready) acc++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("held_accepts", 32'(acc), 32'd2);
      wb = 0;
      while (!rsp_valid && wb < 1000) begin @(negedge clk); wb++; end
      chk("held_done", 32'(rsp_valid), 32'd1);
      repeat (5) @(negedge clk);
      chk("held_bytes", 32'(tx_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < tx_q.size(); i++)
         chk($sformatf("held_byte%0d", i), 32'(tx_q[i]),
             32'(model_frame(1'b1, 12'h8ff, 16'h00ff) >> (8 * (4 - (i % 5)))) & 32'hff);

      // unsolicited response byte while idle
      seen = 0;
      fork
         send_byte(8'h5A, 1'b1);
         repeat (90) begin @(negedge clk); if (rsp_valid || !cmd_ready) seen++; end
      join
      chk("unsol_quiet", 32'(seen), 32'd0);
      repeat (10) @(negedge clk);
      run_txn("rd_after_unsol", 1'b0, 12'h010, 16'h0, 1, 8'h80, 8'h01, 1'b0, 16'h8001,
              model_frame(1'b0, 12'h010, 16'h0), 0);

      // randomized transactions against the reference model
      for (int n = 0; n < 8; n++) begin
         bit          wr;
         logic [11:0] a;
         logic [15:0] d;
         logic [7:0]  r0, r1;
         int          mode;
         wr   = 1'($urandom_range(0, 1));
         a    = 12'($urandom);
         d    = 16'($urandom);
         r0   = 8'($urandom);
         r1   = 8'($urandom);
         mode = wr ? 0 : (($urandom_range(0, 3) == 0) ? 0 : 1);
         run_txn($sformatf("rand%0d", n), wr, a, d, mode, r0, r1,
                 (!wr && mode == 0),
                 (!wr && mode == 1) ? 16'(r0 * 256 + r1) : 16'h0,
                 model_frame(wr, a, d),
                 wr ? 10 * CPB * 5 + 1 : ((mode == 0) ? 10 * CPB * 3 + TO + 1 : 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
